// File: rtl/spi_wb_slave.sv
// SPI mode-0 slave that turns framed SPI transfers into 32-bit Wishbone B3 reads and writes.
// The SPI pins are oversampled in the clk domain, so clk must run at least 8x sclk.
module spi_wb_slave #(
  parameter int          SYNC_STAGES = 2,
  parameter int          WB_TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_WDATA = 3'd3;
  localparam logic [2:0] S_DUMMY = 3'd4;
  localparam logic [2:0] S_RDATA = 3'd5;
  localparam logic [0:0] WB_IDLE = 1'b0;
  localparam logic [0:0] WB_BUSY = 1'b1;
  localparam int          TW      = $clog2(WB_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(WB_TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, ss_sync_q, ss_sync_d, mosi_sync_q, mosi_sync_d;
  logic        sclk_prev_q, sclk_prev_d, ss_prev_q, ss_prev_d;
  logic [2:0]  state_q, state_d, bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] rx_q, rx_d, tx_q, tx_d, addr_q, addr_d, rd_data_q, rd_data_d;
  logic        is_wr_q, is_wr_d, err_flag_q, err_flag_d, load_pend_q, load_pend_d;
  logic        rd_valid_q, rd_valid_d, wb_we_q, wb_we_d;
  logic [0:0]  wb_state_q, wb_state_d;
  logic [31:0] wb_adr_q, wb_adr_d, wb_dat_q, wb_dat_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic        sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall, ss_rise, ss_fall, byte_end;
  logic        wb_busy, wb_fail, wb_done, start_req, start_we, set_err, clr_err;
  logic [31:0] rx_word, start_adr;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign byte_end  = sclk_rise & (bit_cnt_q == 3'd7);
  assign rx_word   = {rx_q[30:0], mosi_s};
  assign wb_busy   = (wb_state_q == WB_BUSY);
  assign wb_fail   = wb_busy & (wb_err_i | wb_rty_i | (to_cnt_q == TO_LAST));
  assign wb_done   = wb_busy & (wb_ack_i | wb_fail);

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_d = sclk_s;
    ss_prev_d   = ss_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    is_wr_d     = is_wr_q;
    addr_d      = addr_q;
    err_flag_d  = err_flag_q;
    load_pend_d = load_pend_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = rd_valid_q;
    wb_state_d  = wb_state_q;
    wb_adr_d    = wb_adr_q;
    wb_dat_d    = wb_dat_q;
    wb_we_d     = wb_we_q;
    to_cnt_d    = to_cnt_q;
    start_req   = 1'b0;
    start_we    = 1'b0;
    start_adr   = addr_q;
    set_err     = 1'b0;
    clr_err     = 1'b0;

    // A freshly received address below takes precedence over the post-cycle increment.
    if (wb_done) addr_d = addr_q + 32'd4;

    if (state_q != S_IDLE && sclk_rise) begin
      rx_d      = rx_word;
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    case (state_q)
      S_CMD: if (byte_end) begin
        is_wr_d    = rx_word[7];
        clr_err    = 1'b1;
        byte_cnt_d = 2'd0;
        state_d    = S_ADDR;
      end
      S_ADDR: if (byte_end) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          addr_d = rx_word;
          if (is_wr_q) begin
            state_d = S_WDATA;
          end else begin
            state_d   = S_DUMMY;
            start_req = 1'b1;
            start_adr = rx_word;
          end
        end
      end
      S_WDATA: if (byte_end) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          if (wb_busy) begin
            set_err = 1'b1;
          end else begin
            start_req = 1'b1;
            start_we  = 1'b1;
          end
        end
      end
      S_DUMMY: if (byte_end) begin
        load_pend_d = 1'b1;
        byte_cnt_d  = 2'd0;
        state_d     = S_RDATA;
      end
      S_RDATA: begin
        // Prefetch the following word while the current one is being shifted out.
        if (sclk_rise && bit_cnt_q == 3'd0 && byte_cnt_q == 2'd0) start_req = 1'b1;
        if (byte_end) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) load_pend_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (state_q != S_IDLE && sclk_fall) begin
      if (load_pend_q) begin
        load_pend_d = 1'b0;
        tx_d        = rd_valid_q ? rd_data_q : ERR_DATA;
        rd_valid_d  = 1'b0;
        if (!rd_valid_q) set_err = 1'b1;
      end else begin
        tx_d = {tx_q[30:0], 1'b0};
      end
    end

    if (wb_busy) begin
      to_cnt_d = to_cnt_q + TW'(1);
      if (wb_done) begin
        wb_state_d = WB_IDLE;
        if (!wb_we_q) begin
          rd_data_d  = wb_fail ? ERR_DATA : wb_dat_i;
          rd_valid_d = 1'b1;
        end
      end
    end else if (start_req) begin
      wb_state_d = WB_BUSY;
      to_cnt_d   = '0;
      wb_adr_d   = start_adr;
      wb_we_d    = start_we;
      if (start_we) wb_dat_d = rx_word;
      else rd_valid_d = 1'b0;
    end
    if (wb_fail) set_err = 1'b1;

    if (ss_rise) begin
      state_d     = S_IDLE;
      load_pend_d = 1'b0;
    end else if (ss_fall) begin
      state_d     = S_CMD;
      bit_cnt_d   = 3'd0;
      byte_cnt_d  = 2'd0;
      load_pend_d = 1'b0;
      tx_d        = {7'd0, err_flag_q, 24'd0};
    end

    if (set_err) err_flag_d = 1'b1;
    else if (clr_err) err_flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 2'd0;
      tx_q        <= '0;
      is_wr_q     <= 1'b0;
      addr_q      <= '0;
      err_flag_q  <= 1'b0;
      load_pend_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      wb_state_q  <= WB_IDLE;
      wb_adr_q    <= '0;
      wb_dat_q    <= '0;
      wb_we_q     <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ss_prev_q   <= ss_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_q        <= tx_d;
      is_wr_q     <= is_wr_d;
      addr_q      <= addr_d;
      err_flag_q  <= err_flag_d;
      load_pend_q <= load_pend_d;
      rd_valid_q  <= rd_valid_d;
      wb_state_q  <= wb_state_d;
      wb_adr_q    <= wb_adr_d;
      wb_dat_q    <= wb_dat_d;
      wb_we_q     <= wb_we_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_q      <= rx_d;
    rd_data_q <= rd_data_d;
  end

  assign spi_miso_oe = ~ss_s;
  assign spi_miso    = ~ss_s & tx_q[31];
  assign wb_cyc_o    = wb_busy;
  assign wb_stb_o    = wb_busy;
  assign wb_we_o     = wb_busy & wb_we_q;
  assign wb_sel_o    = {4{wb_busy}};
  assign wb_adr_o    = wb_adr_q;
  assign wb_dat_o    = wb_dat_q;
endmodule

// File: tb/tb_spi_wb_slave.sv
// Bench for spi_wb_slave: a bit-banged SPI master, a Wishbone slave responder and a
// memory-level reference model of what each frame should produce.
module tb_spi_wb_slave;
  localparam int          HP      = 4;
  localparam int          ACK_LAT = 2;
  localparam int          TMO     = 1024;
  localparam logic [31:0] ERRD    = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sclk = 1'b0;
  logic        spi_ss_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_stb_o, wb_cyc_o;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic        wb_rty_i = 1'b0;

  int total = 0;
  int bad   = 0;
  int resp_mode = 0;
  int cyc_cnt = 0;
  int last_len = 0;
  int cyc_starts = 0;
  int saved_starts;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];
  logic [31:0] slave_mem[logic [31:0]];
  logic [31:0] exp_mem[logic [31:0]];
  logic [31:0] tx_words[$];
  logic [31:0] rx_words[$];
  logic [7:0]  status_b, r8;
  logic [31:0] a;
  int          n;

  spi_wb_slave #(.SYNC_STAGES(2), .WB_TIMEOUT(TMO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o),
    .wb_cyc_o(wb_cyc_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill(input logic [31:0] x);
    return {x[15:0], ~x[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] x);
    return exp_mem.exists(x) ? exp_mem[x] : fill(x);
  endfunction

  // Wishbone slave: terminates each cycle ACK_LAT clocks after it starts, per resp_mode.
  always @(negedge clk) begin
    if (!wb_cyc_o) begin
      if (cyc_cnt > 0) last_len = cyc_cnt;
      cyc_cnt = 0;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    end else begin
      cyc_cnt++;
      if (cyc_cnt == 1) cyc_starts++;
      wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
      if (cyc_cnt == ACK_LAT) begin
        case (resp_mode)
          0: begin
            wb_ack_i = 1'b1;
            log_adr.push_back(wb_adr_o); log_dat.push_back(wb_dat_o);
            log_we.push_back(wb_we_o);   log_sel.push_back(wb_sel_o);
            if (wb_we_o) slave_mem[wb_adr_o] = wb_dat_o;
            else wb_dat_i = slave_mem.exists(wb_adr_o) ? slave_mem[wb_adr_o] : fill(wb_adr_o);
          end
          1: begin wb_err_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF; end
          2: begin wb_rty_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF; end
          default: ;
        endcase
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = tx[i];
      repeat (HP) @(negedge clk);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      repeat (HP) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    spi_ss_n = 1'b0;
    repeat (HP) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (HP) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (6 * HP) @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] adr, input int nw);
    logic [7:0]  r;
    logic [31:0] w;
    frame_begin();
    spi_xfer({1'b1, 7'($urandom)}, status_b);
    for (int i = 3; i >= 0; i--) spi_xfer(adr[8*i +: 8], r);
    for (int k = 0; k < nw; k++) begin
      w = tx_words[k];
      for (int i = 3; i >= 0; i--) spi_xfer(w[8*i +: 8], r);
    end
    frame_end();
  endtask

  task automatic do_read(input logic [31:0] adr, input int nw);
    logic [7:0]  r;
    logic [31:0] w;
    rx_words.delete();
    frame_begin();
    spi_xfer({1'b0, 7'($urandom)}, status_b);
    for (int i = 3; i >= 0; i--) spi_xfer(adr[8*i +: 8], r);
    spi_xfer(8'($urandom), r);
    for (int k = 0; k < nw; k++) begin
      for (int i = 3; i >= 0; i--) begin
        spi_xfer(8'($urandom), r);
        w[8*i +: 8] = r;
      end
      rx_words.push_back(w);
    end
    frame_end();
  endtask

  task automatic clear_log();
    log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete();
  endtask

  // Expected: one write per sent word, at consecutive word addresses, in order.
  task automatic check_writes(input string tag, input logic [31:0] adr, input int nw);
    chk({tag, "_cnt"}, 32'(log_adr.size()), 32'(nw));
    for (int i = 0; i < nw && i < log_adr.size(); i++) begin
      chk({tag, "_adr"}, log_adr[i], adr + 32'(4 * i));
      chk({tag, "_dat"}, log_dat[i], tx_words[i]);
      chk({tag, "_we"},  32'(log_we[i]), 32'd1);
      chk({tag, "_sel"}, 32'(log_sel[i]), 32'hF);
    end
  endtask

  task automatic remember(input logic [31:0] adr, input int nw);
    for (int i = 0; i < nw; i++) exp_mem[adr + 32'(4 * i)] = tx_words[i];
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_ctl"}, {23'd0, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, spi_miso, spi_miso_oe}, 32'd0);
    chk({tag, "_adr"}, wb_adr_o, 32'd0);
    chk({tag, "_dat"}, wb_dat_o, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    slave_mem[32'h20] = 32'h1234_5678;
    exp_mem[32'h20]   = 32'h1234_5678;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // single write
    clear_log(); tx_words.delete(); tx_words.push_back(32'hCAFE_BABE);
    do_write(32'h10, 1);
    chk("w1_status", 32'(status_b), 32'h00);
    check_writes("w1", 32'h10, 1);
    remember(32'h10, 1);

    // single read
    do_read(32'h20, 1);
    chk("r1_status", 32'(status_b), 32'h00);
    chk("r1_word", rx_words[0], 32'h1234_5678);

    // three-word burst write
    clear_log(); tx_words.delete();
    tx_words.push_back(32'h1111_0001); tx_words.push_back(32'h2222_0002); tx_words.push_back(32'h3333_0003);
    do_write(32'h100, 3);
    check_writes("burst", 32'h100, 3);
    remember(32'h100, 3);

    // randomized write/read-back, first one wrapping past 2^32
    for (int it = 0; it < 4; it++) begin
      a = (it == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0FFF_FFFC) | 32'h1000_0000;
      n = (it == 0) ? 3 : $urandom_range(1, 3);
      clear_log(); tx_words.delete();
      for (int k = 0; k < n; k++) tx_words.push_back($urandom);
      do_write(a, n);
      chk("rw_wstatus", 32'(status_b), 32'h00);
      check_writes("rw", a, n);
      remember(a, n);
      do_read(a, n + 1);
      chk("rw_rstatus", 32'(status_b), 32'h00);
      for (int k = 0; k <= n; k++) chk("rw_rdata", rx_words[k], exp_rd(a + 32'(4 * k)));
    end

    // read that never gets an ack
    resp_mode = 3;
    do_read(32'h40, 1);
    chk("to_word", rx_words[0], ERRD);
    for (int i = 0; i < 3 * TMO && wb_cyc_o; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("to_cyc_drop", 32'(wb_cyc_o), 32'd0);
    chk("to_len", 32'(last_len), 32'(TMO));
    resp_mode = 0;
    clear_log(); tx_words.delete(); tx_words.push_back(32'hA5A5_0500);
    do_write(32'h500, 1);
    chk("to_status1", 32'(status_b), 32'h01);
    check_writes("to_w1", 32'h500, 1);
    remember(32'h500, 1);
    do_write(32'h504, 1);
    chk("to_status2", 32'(status_b), 32'h00);

    // frame aborted inside the address
    saved_starts = cyc_starts;
    frame_begin();
    spi_xfer(8'h80, r8); spi_xfer(8'h00, r8); spi_xfer(8'h00, r8);
    frame_end();
    repeat (20) @(negedge clk);
    chk("abort_no_cycle", 32'(cyc_starts), 32'(saved_starts));
    clear_log(); tx_words.delete(); tx_words.push_back($urandom);
    do_write(32'h0000_0A00, 1);
    chk("abort_next_status", 32'(status_b), 32'h00);
    check_writes("abort_next", 32'h0000_0A00, 1);
    remember(32'h0000_0A00, 1);

    // err and rty terminations
    resp_mode = 1;
    clear_log(); tx_words.delete(); tx_words.push_back(32'h0BAD_0200);
    do_write(32'h200, 1);
    chk("err_no_ack", 32'(log_adr.size()), 32'd0);
    resp_mode = 0;
    do_read(32'h10, 1);
    chk("err_status", 32'(status_b), 32'h01);
    chk("err_next_rdata", rx_words[0], exp_rd(32'h10));
    resp_mode = 2;
    do_read(32'h300, 1);
    chk("rty_status", 32'(status_b), 32'h00);
    chk("rty_word", rx_words[0], ERRD);
    resp_mode = 0;
    clear_log(); tx_words.delete(); tx_words.push_back(32'h0600_0600);
    do_write(32'h600, 1);
    chk("rty_next_status", 32'(status_b), 32'h01);

    // reset in the middle of a Wishbone cycle, with the error flag set
    resp_mode = 1;
    do_write(32'h700, 1);
    resp_mode = 3;
    do_write(32'h704, 1);
    chk("rstmid_status", 32'(status_b), 32'h01);
    chk("rstmid_cyc", 32'(wb_cyc_o), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_outputs_zero("rstmid");
    @(negedge clk);
    rst = 1'b1;
    resp_mode = 0;
    repeat (4) @(negedge clk);
    clear_log(); tx_words.delete(); tx_words.push_back(32'h7708_7708);
    do_write(32'h708, 1);
    chk("rstmid_after_status", 32'(status_b), 32'h00);
    check_writes("rstmid_after", 32'h708, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
